dino_game_sequencer: RTL and testbench

Central game-flow controller for the dino runner display pipeline. It sequences IDLE → RUN → OVER → RUN, and derives the score tick from frame-end pulses. It keeps a 5-digit BCD current score and high score that feed the digit-glyph RAM addressing directly. It also produces the obstacle scroll velocity and a one-cycle scene-clear pulse that re-initialises sprite positions on every (re)start.

---
 rtl/dino_game_sequencer.sv | 156 +++++++++++++++
 tb/tb_dino_game_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_game_sequencer.sv
// Game-flow controller for the dino runner: IDLE/RUN/OVER sequencing, 5-digit BCD
// score and high score, obstacle scroll velocity and the scene-clear pulse.
module dino_game_sequencer #(
  parameter int SCORE_DIV  = 4,
  parameter int SPEED_STEP = 100,
  parameter int MAX_VEL    = 8,
  parameter int GO_HOLD    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_end,
  input  logic        start_btn,
  input  logic        collision,
  output logic [1:0]  state,
  output logic        game_on,
  output logic        game_over,
  output logic [19:0] score_bcd,
  output logic [19:0] high_bcd,
  output logic [3:0]  velocity,
  output logic        score_tick,
  output logic        clear_scene
);

  localparam int DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
  localparam int HOLD_W = $clog2(GO_HOLD + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_STEP - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(GO_HOLD);
  localparam logic [3:0]        VEL_MAX   = 4'(MAX_VEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_e;

  // Saturating BCD increment: 99999 stays put, otherwise ripple a decimal carry.
  function automatic logic [19:0] bcd_sat_inc(input logic [19:0] v);
    logic [19:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 20'h99999) begin
      for (int i = 0; i < 5; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] vel_sat_inc(input logic [3:0] v);
    return (v < VEL_MAX) ? v + 4'd1 : v;
  endfunction

  state_e              state_q;
  logic                start_q;
  logic [DIV_W-1:0]    div_q;
  logic [STEP_W-1:0]   step_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [19:0]         score_q, high_q;
  logic [3:0]          vel_q;
  logic                tick_q, clear_q, game_on_q, game_over_q;

  logic                start_rise;
  logic [19:0]         score_d;
  logic [3:0]          vel_d;

  assign start_rise = start_btn & ~start_q;
  assign score_d    = bcd_sat_inc(score_q);
  assign vel_d      = vel_sat_inc(vel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b1;
      div_q       <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      score_q     <= '0;
      high_q      <= '0;
      vel_q       <= 4'd1;
      tick_q      <= 1'b0;
      clear_q     <= 1'b0;
      game_on_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      start_q <= start_btn;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          // IDLE starts on any press; OVER only once the hold period is complete.
          if (start_rise && (state_q == S_IDLE || hold_q == HOLD_MAX)) begin
            state_q     <= S_RUN;
            game_on_q   <= 1'b1;
            game_over_q <= 1'b0;
            clear_q     <= 1'b1;
            score_q     <= '0;
            vel_q       <= 4'd1;
            div_q       <= '0;
            step_q      <= '0;
          end else if (state_q == S_OVER && frame_end && hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        S_RUN: begin
          if (collision) begin
            state_q     <= S_OVER;
            game_on_q   <= 1'b0;
            game_over_q <= 1'b1;
            hold_q      <= '0;
            if (score_q > high_q) high_q <= score_q;
          end else if (frame_end) begin
            if (div_q == DIV_LAST) begin
              div_q   <= '0;
              tick_q  <= 1'b1;
              score_q <= score_d;
              if (step_q == STEP_LAST) begin
                step_q <= '0;
                vel_q  <= vel_d;
              end else begin
                step_q <= step_q + 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          game_on_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign game_on     = game_on_q;
  assign game_over   = game_over_q;
  assign score_bcd   = score_q;
  assign high_bcd    = high_q;
  assign velocity    = vel_q;
  assign score_tick  = tick_q;
  assign clear_scene = clear_q;

endmodule

// File: tb/tb_dino_game_sequencer.sv
// Bench for dino_game_sequencer: integer-level game model compared every cycle,
// plus literal checks at the key moments of two differently-parameterised instances.
module tb_dino_game_sequencer;

  localparam int DIV1 = 4, STEP1 = 100, MAXV = 8, HOLD = 60;
  localparam int DIV2 = 1, STEP2 = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fe1 = 1'b0, sb1 = 1'b1, col1 = 1'b0;
  logic fe2 = 1'b0, sb2 = 1'b0, col2 = 1'b0;

  logic [1:0]  st1, st2;
  logic        on1, on2, ov1, ov2, tk1, tk2, cl1, cl2;
  logic [19:0] sc1, sc2, hi1, hi2;
  logic [3:0]  vl1, vl2;

  int tests = 0, fails = 0;
  int tick_cnt1 = 0, tick_cnt2 = 0;

  always #5 clk = ~clk;

  dino_game_sequencer #(.SCORE_DIV(DIV1), .SPEED_STEP(STEP1), .MAX_VEL(MAXV), .GO_HOLD(HOLD)) dut1 (
    .clk(clk), .reset(reset), .frame_end(fe1), .start_btn(sb1), .collision(col1),
    .state(st1), .game_on(on1), .game_over(ov1), .score_bcd(sc1), .high_bcd(hi1),
    .velocity(vl1), .score_tick(tk1), .clear_scene(cl1));

  dino_game_sequencer #(.SCORE_DIV(DIV2), .SPEED_STEP(STEP2), .MAX_VEL(MAXV), .GO_HOLD(HOLD)) dut2 (
    .clk(clk), .reset(reset), .frame_end(fe2), .start_btn(sb2), .collision(col2),
    .state(st2), .game_on(on2), .game_over(ov2), .score_bcd(sc2), .high_bcd(hi2),
    .velocity(vl2), .score_tick(tk2), .clear_scene(cl2));

  // Game model: state 0/1/2, total score ticks since the run began, high score as integer.
  typedef struct {
    int st;
    int ticks;
    int frames;
    int high;
    int over;
    bit prev;
    bit tick;
    bit clr;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.st = 0; m.ticks = 0; m.frames = 0; m.high = 0; m.over = 0;
    m.prev = 1'b1; m.tick = 1'b0; m.clr = 1'b0;
    return m;
  endfunction

  function automatic int sat_score(input int t);
    return (t > 99999) ? 99999 : t;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit fe, input bit sb, input bit col,
                                    input int div, input int hold);
    bit rise;
    rise   = sb && !m.prev;
    m.prev = sb;
    m.tick = 1'b0;
    m.clr  = 1'b0;
    if ((m.st == 0 && rise) || (m.st == 2 && rise && m.over >= hold)) begin
      m.st = 1; m.ticks = 0; m.frames = 0; m.clr = 1'b1;
    end else if (m.st == 1) begin
      if (col) begin
        m.st = 2; m.over = 0;
        if (sat_score(m.ticks) > m.high) m.high = sat_score(m.ticks);
      end else if (fe) begin
        m.frames++;
        if (m.frames % div == 0) begin
          m.ticks++;
          m.tick = 1'b1;
        end
      end
    end else if (m.st == 2 && fe && m.over < hold) begin
      m.over++;
    end
    return m;
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int exp_vel(input int ticks, input int step);
    int v;
    v = 1 + ticks / step;
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input mdl_t m, input int step,
                         input logic [1:0] st, input logic on, input logic ov,
                         input logic [19:0] sc, input logic [19:0] hi, input logic [3:0] vl,
                         input logic tk, input logic cl);
    check({tag, ".state"},      32'(st), 32'(m.st));
    check({tag, ".game_on"},    32'(on), 32'(m.st == 1));
    check({tag, ".game_over"},  32'(ov), 32'(m.st == 2));
    check({tag, ".score"},      32'(sc), 32'(to_bcd(sat_score(m.ticks))));
    check({tag, ".high"},       32'(hi), 32'(to_bcd(m.high)));
    check({tag, ".velocity"},   32'(vl), 32'(exp_vel(m.ticks, step)));
    check({tag, ".score_tick"}, 32'(tk), 32'(m.tick));
    check({tag, ".clear"},      32'(cl), 32'(m.clr));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 = mdl_init();
      m2 = mdl_init();
    end else begin
      m1 = mdl_step(m1, fe1, sb1, col1, DIV1, HOLD);
      m2 = mdl_step(m2, fe2, sb2, col2, DIV2, HOLD);
    end
  end

  always @(negedge clk) begin
    cmp_all("d1", m1, STEP1, st1, on1, ov1, sc1, hi1, vl1, tk1, cl1);
    cmp_all("d2", m2, STEP2, st2, on2, ov2, sc2, hi2, vl2, tk2, cl2);
    if (tk1) tick_cnt1++;
    if (tk2) tick_cnt2++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frames(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 1) fe1 = 1'b1; else fe2 = 1'b1;
      cyc(1);
      if (which == 1) fe1 = 1'b0; else fe2 = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    // reset held with the button down
    cyc(3);
    check("rst_state", 32'(st1), 32'd0);
    check("rst_score", 32'(sc1), 32'd0);
    check("rst_high",  32'(hi1), 32'd0);
    check("rst_vel",   32'(vl1), 32'd1);
    reset = 1'b0;
    cyc(4);
    check("held_btn_idle", 32'(st1), 32'd0);
    sb1 = 1'b0;
    cyc(2);
    check("release_idle", 32'(st1), 32'd0);
    sb1 = 1'b1;
    cyc(1);
    check("start_state", 32'(st1), 32'h1);
    check("start_clear", 32'(cl1), 32'd1);
    check("start_score", 32'(sc1), 32'd0);
    check("start_vel",   32'(vl1), 32'd1);
    sb1 = 1'b0;
    cyc(1);
    check("clear_1cyc", 32'(cl1), 32'd0);

    // score 3 with divider at 3, then collision coincident with frame_end
    frames(1, 15);
    check("pre_col_score", 32'(sc1), 32'h00003);
    fe1 = 1'b1; col1 = 1'b1;
    cyc(1);
    fe1 = 1'b0; col1 = 1'b0;
    check("col_state", 32'(st1), 32'h2);
    check("col_score", 32'(sc1), 32'h00003);
    check("col_notick", 32'(tk1), 32'd0);
    check("col_high", 32'(hi1), 32'h00003);

    // early restart dropped, late restart accepted
    frames(1, 10);
    sb1 = 1'b1; cyc(1); sb1 = 1'b0; cyc(1);
    check("early_start_ignored", 32'(st1), 32'h2);
    frames(1, 50);
    sb1 = 1'b1;
    cyc(1);
    check("restart_state", 32'(st1), 32'h1);
    check("restart_clear", 32'(cl1), 32'd1);
    check("restart_score", 32'(sc1), 32'd0);
    check("restart_high",  32'(hi1), 32'h00003);
    sb1 = 1'b0;
    cyc(1);
    frames(1, 8);
    col1 = 1'b1; cyc(1); col1 = 1'b0;
    check("die_at2_score", 32'(sc1), 32'h00002);
    check("die_at2_high",  32'(hi1), 32'h00003);

    // long run: scoring rate and first velocity step
    frames(1, 60);
    sb1 = 1'b1; cyc(1); sb1 = 1'b0; cyc(1);
    tick_cnt1 = 0;
    frames(1, 40);
    check("ticks_40fr", 32'(tick_cnt1), 32'd10);
    check("score_40fr", 32'(sc1), 32'h00010);
    frames(1, 360);
    check("score_400fr", 32'(sc1), 32'h00100);
    check("vel_400fr", 32'(vl1), 32'd2);
    col1 = 1'b1; cyc(1); col1 = 1'b0;
    check("high_100", 32'(hi1), 32'h00100);
    frames(1, 60);
    sb1 = 1'b1; cyc(1); sb1 = 1'b0; cyc(1);
    frames(1, 228);
    check("score_57", 32'(sc1), 32'h00057);

    // second instance: one tick per frame, velocity saturation and score saturation
    sb2 = 1'b1; cyc(1); sb2 = 1'b0; cyc(1);
    frames(2, 10);
    check("d2_score10", 32'(sc2), 32'h00010);
    check("d2_vel_sat", 32'(vl2), 32'd8);
    force dut2.score_q = 20'h99990;
    m2.ticks  = 99990;
    m2.frames = 99990;
    cyc(1);
    release dut2.score_q;
    cyc(1);
    check("d2_preset", 32'(sc2), 32'h99990);
    tick_cnt2 = 0;
    frames(2, 12);
    check("d2_score_sat", 32'(sc2), 32'h99999);
    check("d2_ticks_at_sat", 32'(tick_cnt2), 32'd12);
    check("d2_vel_final", 32'(vl2), 32'd8);

    // asynchronous reset mid-run, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    check("async_state", 32'(st1), 32'd0);
    check("async_score", 32'(sc1), 32'd0);
    check("async_high",  32'(hi1), 32'd0);
    check("async_vel",   32'(vl1), 32'd1);
    check("async_on",    32'(on1), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
